scdpram_pipe: RTL and testbench



---
 rtl/scdpram_pkg.sv | 7 +
 rtl/scdpram_pipe_if.sv | 25 ++
 rtl/scdpram_lane_merge.sv | 17 +
 rtl/scdpram_pipe.sv | 72 +++++++
 tb/tb_scdpram_pipe.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/scdpram_pkg.sv
// scdpram_pkg: shared types and elaboration helpers for the simple-dual-port RAM
package scdpram_pkg;
  typedef enum logic {RDW_NEW, RDW_OLD} rdw_mode_e;
  function automatic int lanes(input int width, input int lane_w);
    return width / lane_w;
  endfunction
endpackage

// File: rtl/scdpram_pipe_if.sv
// scdpram_pipe_if: write/read port bundle of the simple-dual-port RAM
interface scdpram_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int LANE_W = 8,
  parameter int ADDR   = 4
);
  import scdpram_pkg::*;
  localparam int LANES = lanes(WIDTH, LANE_W);
  logic             i_wr_ena;
  logic [ADDR-1:0]  i_wr_addr;
  logic [LANES-1:0] i_wr_lane;
  logic [WIDTH-1:0] i_data;
  logic             i_rd_ena;
  logic [ADDR-1:0]  i_rd_addr;
  logic [WIDTH-1:0] o_data;
  logic             o_rd_valid;
  modport master (
    output i_wr_ena, i_wr_addr, i_wr_lane, i_data, i_rd_ena, i_rd_addr,
    input  o_data, o_rd_valid
  );
  modport slave (
    input  i_wr_ena, i_wr_addr, i_wr_lane, i_data, i_rd_ena, i_rd_addr,
    output o_data, o_rd_valid
  );
endinterface

// File: rtl/scdpram_lane_merge.sv
// scdpram_lane_merge: per-lane select between incoming write data and the stored word
module scdpram_lane_merge
  import scdpram_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LANE_W = 8,
  parameter int LANES  = lanes(WIDTH, LANE_W)
) (
  input  logic [WIDTH-1:0] new_data,
  input  logic [WIDTH-1:0] old_data,
  input  logic [LANES-1:0] lane,
  output logic [WIDTH-1:0] merged
);
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign merged[g*LANE_W +: LANE_W] = lane[g] ? new_data[g*LANE_W +: LANE_W] : old_data[g*LANE_W +: LANE_W];
  end
endmodule

// File: rtl/scdpram_pipe.sv
// scdpram_pipe: single-clock simple-dual-port RAM with lane writes, selectable
// read-during-write result and an optional second output register stage
module scdpram_pipe
  import scdpram_pkg::*;
#(
  parameter int        WIDTH    = 32,
  parameter int        LANE_W   = 8,
  parameter int        DEPTH    = 16,
  parameter int        ADDR     = $clog2(DEPTH),
  parameter rdw_mode_e RDW_MODE = RDW_NEW,
  parameter bit        OUT_REG  = 1'b0
) (
  input logic           clk,
  input logic           reset_n,
  scdpram_pipe_if.slave bus
);
  localparam int LANES = lanes(WIDTH, LANE_W);
  localparam logic [ADDR:0] LIMIT = (ADDR+1)'(DEPTH);
  if (WIDTH % LANE_W != 0 || DEPTH < 2) begin : g_bad_cfg
    $error("scdpram_pipe: WIDTH must be a multiple of LANE_W and DEPTH must be at least 2");
  end
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_go;
  logic             rd_hit;
  logic [LANES-1:0] byp_lane;
  logic [WIDTH-1:0] stored;
  logic [WIDTH-1:0] rd_next;
  logic [WIDTH-1:0] rd_q;
  logic             rd_v;
  // writes are suppressed while reset is held so the array keeps its contents
  assign wr_go    = bus.i_wr_ena && reset_n && ({1'b0, bus.i_wr_addr} < LIMIT);
  assign rd_hit   = {1'b0, bus.i_rd_addr} < LIMIT;
  assign stored   = rd_hit ? mem[bus.i_rd_addr] : '0;
  assign byp_lane = (RDW_MODE == RDW_NEW && wr_go && bus.i_wr_addr == bus.i_rd_addr) ? bus.i_wr_lane : '0;
  scdpram_lane_merge #(
    .WIDTH  (WIDTH),
    .LANE_W (LANE_W)
  ) u_merge (
    .new_data (bus.i_data),
    .old_data (stored),
    .lane     (byp_lane),
    .merged   (rd_next)
  );
  always_ff @(posedge clk)
    for (int k = 0; k < LANES; k++)
      if (wr_go && bus.i_wr_lane[k]) mem[bus.i_wr_addr][k*LANE_W +: LANE_W] <= bus.i_data[k*LANE_W +: LANE_W];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_q <= '0;
      rd_v <= 1'b0;
    end else begin
      rd_v <= bus.i_rd_ena;
      if (bus.i_rd_ena) rd_q <= rd_next;
    end
  if (OUT_REG) begin : g_out_reg
    logic [WIDTH-1:0] out_q;
    logic             out_v;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        out_q <= '0;
        out_v <= 1'b0;
      end else begin
        out_v <= rd_v;
        if (rd_v) out_q <= rd_q;
      end
    assign bus.o_data     = out_q;
    assign bus.o_rd_valid = out_v;
  end else begin : g_direct
    assign bus.o_data     = rd_q;
    assign bus.o_rd_valid = rd_v;
  end
endmodule

// File: tb/tb_scdpram_pipe.sv
// tb_scdpram_pipe: directed vectors against two configurations driven in lockstep
module tb_scdpram_pipe;
  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [3:0]  wl;
    logic [31:0] wd;
    logic        re;
    logic [3:0]  ra;
    logic        va;
    logic [31:0] da;
    logic        vb;
    logic [31:0] db;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_ena = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  wr_lane = '0;
  logic [31:0] wr_data = '0;
  logic        rd_ena = 1'b0;
  logic [3:0]  rd_addr = '0;
  int          checks = 0;
  int          failures = 0;
  vec_t        tbl[$];
  always #5 clk = ~clk;
  scdpram_pipe_if #(.WIDTH(32), .LANE_W(8), .ADDR(4)) ifa ();
  scdpram_pipe_if #(.WIDTH(32), .LANE_W(8), .ADDR(4)) ifb ();
  assign ifa.i_wr_ena  = wr_ena;
  assign ifa.i_wr_addr = wr_addr;
  assign ifa.i_wr_lane = wr_lane;
  assign ifa.i_data    = wr_data;
  assign ifa.i_rd_ena  = rd_ena;
  assign ifa.i_rd_addr = rd_addr;
  assign ifb.i_wr_ena  = wr_ena;
  assign ifb.i_wr_addr = wr_addr;
  assign ifb.i_wr_lane = wr_lane;
  assign ifb.i_data    = wr_data;
  assign ifb.i_rd_ena  = rd_ena;
  assign ifb.i_rd_addr = rd_addr;
  // A: depth 16, new-data bypass, one-cycle latency
  scdpram_pipe #(
    .WIDTH(32), .LANE_W(8), .DEPTH(16), .RDW_MODE(scdpram_pkg::RDW_NEW), .OUT_REG(1'b0)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa)
  );
  // B: depth 12, old-data result, two-cycle latency
  scdpram_pipe #(
    .WIDTH(32), .LANE_W(8), .DEPTH(12), .RDW_MODE(scdpram_pkg::RDW_OLD), .OUT_REG(1'b1)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic idle();
    wr_ena = 1'b0;
    wr_lane = '0;
    rd_ena = 1'b0;
  endtask
  task automatic add(input logic we, input logic [3:0] wa, input logic [3:0] wl, input logic [31:0] wd,
                     input logic re, input logic [3:0] ra, input logic va, input logic [31:0] da,
                     input logic vb, input logic [31:0] db);
    vec_t t;
    t = '{we, wa, wl, wd, re, ra, va, da, vb, db};
    tbl.push_back(t);
  endtask
  initial begin
    logic [3:0] pa;
    logic [3:0] pb;
    logic       any_v;
    //  we  wa     wl      wd            re  ra      va  da            vb  db
    add(1, 4'd0,  4'hF, 32'd10,        0, 4'd0,  0, 32'd0,        0, 32'd0);
    add(1, 4'd1,  4'hF, 32'd11,        0, 4'd0,  0, 32'd0,        0, 32'd0);
    add(1, 4'd2,  4'hF, 32'd12,        0, 4'd0,  0, 32'd0,        0, 32'd0);
    add(1, 4'd11, 4'hF, 32'h0B0B0B0B,  0, 4'd0,  0, 32'd0,        0, 32'd0);
    add(1, 4'd5,  4'hF, 32'h0,         0, 4'd0,  0, 32'd0,        0, 32'd0);
    add(1, 4'd3,  4'hF, 32'hAABBCCDD,  0, 4'd0,  0, 32'd0,        0, 32'd0);
    add(1, 4'd3,  4'h5, 32'h11223344,  0, 4'd0,  0, 32'd0,        0, 32'd0);
    add(0, 4'd0,  4'h0, 32'h0,         1, 4'd3,  1, 32'hAA22CC44, 0, 32'd0);
    add(0, 4'd0,  4'h0, 32'h0,         1, 4'd0,  1, 32'd10,       1, 32'hAA22CC44);
    add(0, 4'd0,  4'h0, 32'h0,         1, 4'd1,  1, 32'd11,       1, 32'd10);
    add(0, 4'd0,  4'h0, 32'h0,         1, 4'd2,  1, 32'd12,       1, 32'd11);
    add(0, 4'd0,  4'h0, 32'h0,         0, 4'd0,  0, 32'd12,       1, 32'd12);
    add(0, 4'd0,  4'h0, 32'h0,         0, 4'd0,  0, 32'd12,       0, 32'd12);
    add(1, 4'd5,  4'h3, 32'hFFFFFFFF,  1, 4'd5,  1, 32'h0000FFFF, 0, 32'd12);
    add(0, 4'd0,  4'h0, 32'h0,         1, 4'd5,  1, 32'h0000FFFF, 1, 32'h0);
    add(1, 4'd13, 4'hF, 32'h0000DEAD,  0, 4'd0,  0, 32'h0000FFFF, 1, 32'h0000FFFF);
    add(0, 4'd0,  4'h0, 32'h0,         1, 4'd13, 1, 32'h0000DEAD, 0, 32'h0000FFFF);
    add(0, 4'd0,  4'h0, 32'h0,         1, 4'd11, 1, 32'h0B0B0B0B, 1, 32'h0);
    add(0, 4'd0,  4'h0, 32'h0,         0, 4'd0,  0, 32'h0B0B0B0B, 1, 32'h0B0B0B0B);
    add(1, 4'd11, 4'h0, 32'hFFFFFFFF,  1, 4'd11, 1, 32'h0B0B0B0B, 0, 32'h0B0B0B0B);
    add(0, 4'd0,  4'h0, 32'h0,         1, 4'd11, 1, 32'h0B0B0B0B, 1, 32'h0B0B0B0B);
    add(1, 4'd12, 4'hF, 32'h12121212,  1, 4'd12, 1, 32'h12121212, 1, 32'h0B0B0B0B);
    add(0, 4'd0,  4'h0, 32'h0,         0, 4'd0,  0, 32'h12121212, 1, 32'h0);
    // reset hold with inputs toggling
    for (int i = 0; i < 5; i++) begin
      wr_ena = 1'($urandom);
      wr_addr = 4'($urandom);
      wr_lane = 4'($urandom);
      wr_data = $urandom;
      rd_ena = 1'($urandom);
      rd_addr = 4'($urandom);
      cyc();
      chk($sformatf("hold%0d A data", i), ifa.o_data, 32'd0);
      chk($sformatf("hold%0d A valid", i), 32'(ifa.o_rd_valid), 32'd0);
      chk($sformatf("hold%0d B data", i), ifb.o_data, 32'd0);
      chk($sformatf("hold%0d B valid", i), 32'(ifb.o_rd_valid), 32'd0);
    end
    idle();
    rd_ena = 1'b1;
    rd_addr = 4'd0;
    reset_n = 1'b1;
    pa = '0;
    pb = '0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      rd_ena = 1'b0;
      pa[i] = ifa.o_rd_valid;
      pb[i] = ifb.o_rd_valid;
    end
    chk("release A valid pattern", 32'(pa), 32'b0001);
    chk("release B valid pattern", 32'(pb), 32'b0010);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    // table: A shows this row's read, B shows the previous row's read
    foreach (tbl[i]) begin
      wr_ena = tbl[i].we;
      wr_addr = tbl[i].wa;
      wr_lane = tbl[i].wl;
      wr_data = tbl[i].wd;
      rd_ena = tbl[i].re;
      rd_addr = tbl[i].ra;
      cyc();
      chk($sformatf("row%0d A valid", i), 32'(ifa.o_rd_valid), 32'(tbl[i].va));
      chk($sformatf("row%0d A data", i), ifa.o_data, tbl[i].da);
      chk($sformatf("row%0d B valid", i), 32'(ifb.o_rd_valid), 32'(tbl[i].vb));
      chk($sformatf("row%0d B data", i), ifb.o_data, tbl[i].db);
    end
    idle();
    // reset with a read still inside B's pipeline
    rd_ena = 1'b1;
    rd_addr = 4'd1;
    cyc();
    rd_addr = 4'd2;
    cyc();
    chk("pre-reset B data", ifb.o_data, 32'd11);
    chk("pre-reset B valid", 32'(ifb.o_rd_valid), 32'd1);
    rd_ena = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("async reset A data", ifa.o_data, 32'd0);
    chk("async reset A valid", 32'(ifa.o_rd_valid), 32'd0);
    chk("async reset B data", ifb.o_data, 32'd0);
    chk("async reset B valid", 32'(ifb.o_rd_valid), 32'd0);
    any_v = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      any_v = any_v | ifa.o_rd_valid | ifb.o_rd_valid;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      any_v = any_v | ifa.o_rd_valid | ifb.o_rd_valid;
    end
    chk("no valid after reset", 32'(any_v), 32'd0);
    rd_ena = 1'b1;
    rd_addr = 4'd1;
    cyc();
    rd_ena = 1'b0;
    chk("post-reset A valid", 32'(ifa.o_rd_valid), 32'd1);
    chk("post-reset A data", ifa.o_data, 32'd11);
    chk("post-reset B early valid", 32'(ifb.o_rd_valid), 32'd0);
    cyc();
    chk("post-reset A valid drop", 32'(ifa.o_rd_valid), 32'd0);
    chk("post-reset B valid", 32'(ifb.o_rd_valid), 32'd1);
    chk("post-reset B data", ifb.o_data, 32'd11);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
